uart_reg_responder: RTL and testbench
=====================================

Name: uart_reg_responder

Overview:
Byte-level command responder at the far end of the UART tx/rx byte interface. It consumes received bytes (rx_data/rx_done), parses write and read commands against a small internal register file, and returns one response byte through the transmitter handshake (tx_start/tx_data/tx_done). It sits above the UART top level and gives a host PC register access to the FPGA design over the serial link.

Parameters:
NUM_REGS, 16, number of 8-bit registers; address width is $clog2(NUM_REGS).
TIMEOUT_CYCLES, 1_000_000, clk cycles allowed between bytes of one command before the command is aborted.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset; reset==0 at a clk edge resets the block
rx_data  input  8  received byte, valid while rx_done=1
rx_done  input  1  one-cycle pulse, one byte received
tx_done  input  1  one-cycle pulse, transmitter finished the frame
tx_start  output  1  one-cycle pulse requesting transmission of tx_data
tx_data  output  8  response byte, held stable from tx_start until tx_done
regs_flat  output  NUM_REGS*8  register file, reg k at bits [8k+7:8k]
busy  output  1  1 whenever state != IDLE
err_cnt  output  8  saturating count of error events

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, all registers=0, tx_start=0, tx_data=0, err_cnt=0, busy=0, timeout counter=0. Reset overrides everything, including in mid-command or in WAIT_TX.
- Protocol: write = 0x57 ('W'), addr, data -> response 0x41 ('A'). Read = 0x52 ('R'), addr -> response is reg[addr].
- Error response is 0x3F ('?') in two cases: unknown opcode, or addr >= NUM_REGS. An out-of-range write still consumes its data byte, performs no write, then responds 0x3F.
- FSM states: IDLE, GET_ADDR, GET_DATA, WAIT_TX.
  - IDLE, rx_done: opcode 0x57 or 0x52 -> GET_ADDR, opcode latched. Any other opcode -> WAIT_TX with response 0x3F, err_cnt+1.
  - GET_ADDR, rx_done: write opcode -> GET_DATA, addr latched. Read opcode -> WAIT_TX; response is reg[addr], or 0x3F if out of range.
  - GET_DATA, rx_done: in-range addr -> reg[addr]<=rx_data at this edge, response 0x41. Out-of-range addr -> response 0x3F, err_cnt+1. Either way -> WAIT_TX.
  - WAIT_TX, tx_done -> IDLE. Any rx_done seen in WAIT_TX (including the same cycle as tx_done) drops that byte and increments err_cnt.
- tx_start and tx_data are registered. The edge that samples the final command byte (rx_done=1 in cycle N) loads tx_data and sets tx_start. tx_start is therefore high in cycle N+1 only, and tx_data holds until the edge that samples tx_done.
- regs_flat reflects a write from cycle N+1. A read issued in the same cycle as a write cannot occur, since only one byte arrives per rx_done.
- Timeout:
  - The counter clears on every rx_done and increments each cycle in GET_ADDR or GET_DATA.
  - When it reaches TIMEOUT_CYCLES-1: -> IDLE, no response, no write, err_cnt+1.
  - The counter does not run in IDLE or WAIT_TX.
- tx_done outside WAIT_TX is ignored.
- err_cnt saturates at 255; further errors leave it at 255.
- Every rx_done pulse is consumed as exactly one byte; the data value is ignored when rx_done=0.

Test Plan:
- Write: rx bytes 0x57,0x03,0xA5 -> tx_start one cycle after the 3rd rx_done with tx_data=0x41; regs_flat[31:24]=0xA5 from that cycle; pulse tx_done -> busy=0.
- Read-back: after the write, rx 0x52,0x03 -> tx_data=0xA5 with a single-cycle tx_start; 0x52,0x00 -> tx_data=0x00.
- Errors: opcode 0x10 -> tx_data=0x3F, err_cnt=1. 0x57,0x10,0xFF with NUM_REGS=16 -> 0x3F, regs_flat unchanged, err_cnt=2. 0x52,0x20 -> 0x3F, err_cnt=3.
- Timeout (TIMEOUT_CYCLES=50): 0x57 then idle 50 cycles -> busy falls, no tx_start, err_cnt+1; then 0x52,0x03 is parsed normally.
- Overrun: in WAIT_TX, pulse rx_done with 0x57 (also once coincident with tx_done) -> byte dropped, err_cnt+1 each; after tx_done a new 0x52,0x03 returns the correct data.
- Reset mid-command: 0x57,0x05, then reset=0 for one edge, then 0xAA -> 0xAA is treated as an opcode (0x3F response), reg5=0, err_cnt=1.

Source files
------------

// File: rtl/uart_reg_responder_if.sv
// Byte-level handshake between the UART byte engine and the register responder.
// The UART side is the master; the responder is the slave.
interface uart_reg_responder_if;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;

  modport master (
    output rx_data, rx_done, tx_done,
    input  tx_start, tx_data
  );

  modport slave (
    input  rx_data, rx_done, tx_done,
    output tx_start, tx_data
  );
endinterface

// File: rtl/uart_reg_responder.sv
// Parses 'W' addr data / 'R' addr commands from received UART bytes against a small
// register file and answers each command with a single response byte.
module uart_reg_responder #(
  parameter int NUM_REGS       = 16,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_reg_responder_if.slave   bus,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  busy,
  output logic [7:0]            err_cnt
);

  localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK  = 8'h41;
  localparam logic [7:0] RSP_ERR  = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    WAIT_TX
  } state_t;

  state_t        state_reg;
  logic          op_write_reg;
  logic [AW-1:0] addr_reg;
  logic          addr_ok_reg;
  logic [TW-1:0] timer_reg;
  logic [7:0]    err_cnt_reg;
  logic          tx_start_reg;
  logic [7:0]    tx_data_reg;
  logic [7:0]    regs_mem [NUM_REGS];

  logic opcode_ok;
  logic rx_in_range;
  logic timer_expired;
  logic err_event;

  always_comb begin
    opcode_ok     = (bus.rx_data == OP_WRITE) || (bus.rx_data == OP_READ);
    rx_in_range   = ({1'b0, bus.rx_data} < NUM_REGS_W);
    timer_expired = !bus.rx_done && (timer_reg == TIMER_LAST);
    err_event     = 1'b0;
    case (state_reg)
      IDLE:     err_event = bus.rx_done && !opcode_ok;
      GET_ADDR: err_event = (bus.rx_done && !op_write_reg && !rx_in_range) || timer_expired;
      GET_DATA: err_event = (bus.rx_done && !addr_ok_reg) || timer_expired;
      WAIT_TX:  err_event = bus.rx_done;
      default:  err_event = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      op_write_reg <= 1'b0;
      addr_reg     <= '0;
      addr_ok_reg  <= 1'b0;
      timer_reg    <= '0;
      err_cnt_reg  <= 8'd0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= 8'd0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_mem[i] <= 8'd0;
      end
    end else begin
      tx_start_reg <= 1'b0;
      if (err_event && (err_cnt_reg != 8'hFF)) begin
        err_cnt_reg <= err_cnt_reg + 8'd1;
      end
      // Every received byte restarts the inter-byte window; it only advances mid-command.
      if (bus.rx_done) begin
        timer_reg <= '0;
      end

      case (state_reg)
        IDLE: begin
          if (bus.rx_done) begin
            if (opcode_ok) begin
              op_write_reg <= (bus.rx_data == OP_WRITE);
              state_reg    <= GET_ADDR;
            end else begin
              tx_data_reg  <= RSP_ERR;
              tx_start_reg <= 1'b1;
              state_reg    <= WAIT_TX;
            end
          end
        end

        GET_ADDR: begin
          if (bus.rx_done) begin
            if (op_write_reg) begin
              addr_reg    <= bus.rx_data[AW-1:0];
              addr_ok_reg <= rx_in_range;
              state_reg   <= GET_DATA;
            end else begin
              tx_data_reg  <= rx_in_range ? regs_mem[bus.rx_data[AW-1:0]] : RSP_ERR;
              tx_start_reg <= 1'b1;
              state_reg    <= WAIT_TX;
            end
          end else if (timer_expired) begin
            timer_reg <= '0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        GET_DATA: begin
          if (bus.rx_done) begin
            // Out-of-range writes still swallow their data byte before answering '?'.
            if (addr_ok_reg) begin
              regs_mem[addr_reg] <= bus.rx_data;
              tx_data_reg        <= RSP_ACK;
            end else begin
              tx_data_reg <= RSP_ERR;
            end
            tx_start_reg <= 1'b1;
            state_reg    <= WAIT_TX;
          end else if (timer_expired) begin
            timer_reg <= '0;
            state_reg <= IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        WAIT_TX: begin
          if (bus.tx_done) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_flat
      assign regs_flat[gi*8 +: 8] = regs_mem[gi];
    end
  endgenerate

  assign bus.tx_start = tx_start_reg;
  assign bus.tx_data  = tx_data_reg;
  assign busy         = (state_reg != IDLE);
  assign err_cnt      = err_cnt_reg;

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: writes, reads, error responses, timeout,
// overrun, mid-command reset and error-counter saturation.
module tb_uart_reg_responder;
  localparam int NUM_REGS = 16;
  localparam int TIMEOUT  = 50;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_REGS*8-1:0] regs_flat;
  logic busy;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  uart_reg_responder_if bus ();

  uart_reg_responder #(
    .NUM_REGS      (NUM_REGS),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .regs_flat(regs_flat),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    @(posedge clk); #1;
    bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.tx_done = 1'b0;
  endtask

  // Called right after the final command byte: response must be presented now.
  task automatic expect_response(input string tag, input logic [7:0] rsp);
    check({tag, " tx_start"}, 128'(bus.tx_start), 128'd1);
    check({tag, " tx_data"}, 128'(bus.tx_data), 128'(rsp));
    check({tag, " busy"}, 128'(busy), 128'd1);
    @(posedge clk); #1;
    check({tag, " tx_start pulse"}, 128'(bus.tx_start), 128'd0);
    check({tag, " tx_data hold"}, 128'(bus.tx_data), 128'(rsp));
    pulse_tx_done();
    check({tag, " idle"}, 128'(busy), 128'd0);
    $display("txn %s: response %02h err_cnt %0d", tag, bus.tx_data, err_cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen_start;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 128'(busy), 128'd0);
    check("reset tx_start", 128'(bus.tx_start), 128'd0);
    check("reset tx_data", 128'(bus.tx_data), 128'd0);
    check("reset err_cnt", 128'(err_cnt), 128'd0);
    check("reset regs", 128'(regs_flat), 128'd0);
    reset = 1'b1;

    // tx_done outside WAIT_TX is ignored
    pulse_tx_done();
    check("stray tx_done busy", 128'(busy), 128'd0);

    // write reg3 = A5
    send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
    check("write reg3", 128'(regs_flat[31:24]), 128'hA5);
    check("write regs_flat", 128'(regs_flat), 128'h0000_0000_0000_0000_0000_0000_A500_0000);
    expect_response("write", 8'h41);

    send_byte(8'h52); send_byte(8'h03);
    expect_response("read3", 8'hA5);
    send_byte(8'h52); send_byte(8'h00);
    expect_response("read0", 8'h00);
    check("no errors yet", 128'(err_cnt), 128'd0);

    send_byte(8'h10);
    expect_response("bad opcode", 8'h3F);
    check("bad opcode err", 128'(err_cnt), 128'd1);

    send_byte(8'h57); send_byte(8'h10); send_byte(8'hFF);
    expect_response("write oor", 8'h3F);
    check("write oor err", 128'(err_cnt), 128'd2);
    check("write oor regs", 128'(regs_flat), 128'h0000_0000_0000_0000_0000_0000_A500_0000);

    send_byte(8'h52); send_byte(8'h20);
    expect_response("read oor", 8'h3F);
    check("read oor err", 128'(err_cnt), 128'd3);

    // read of the last valid register
    send_byte(8'h52); send_byte(8'h0F);
    expect_response("read15", 8'h00);

    // timeout: opcode then silence; aborts on the 50th edge after the opcode edge
    send_byte(8'h57);
    seen_start = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      @(posedge clk); #1;
      if (bus.tx_start) seen_start = 1'b1;
    end
    check("timeout busy before", 128'(busy), 128'd1);
    @(posedge clk); #1;
    check("timeout busy after", 128'(busy), 128'd0);
    check("timeout no tx_start", 128'(seen_start | bus.tx_start), 128'd0);
    check("timeout err", 128'(err_cnt), 128'd4);
    $display("txn timeout: err_cnt %0d", err_cnt);
    send_byte(8'h52); send_byte(8'h03);
    expect_response("read after timeout", 8'hA5);

    // overrun in WAIT_TX, then coincident with tx_done
    send_byte(8'h52); send_byte(8'h03);
    check("overrun rsp", 128'(bus.tx_data), 128'hA5);
    send_byte(8'h57);
    check("overrun err", 128'(err_cnt), 128'd5);
    check("overrun still waiting", 128'(busy), 128'd1);
    @(posedge clk); #1;
    bus.rx_data = 8'h57; bus.rx_done = 1'b1; bus.tx_done = 1'b1;
    @(posedge clk); #1;
    bus.rx_done = 1'b0; bus.tx_done = 1'b0;
    check("overrun coincident err", 128'(err_cnt), 128'd6);
    check("overrun coincident idle", 128'(busy), 128'd0);
    $display("txn overrun: err_cnt %0d", err_cnt);
    send_byte(8'h52); send_byte(8'h03);
    expect_response("read after overrun", 8'hA5);

    // reset in the middle of a write
    send_byte(8'h57); send_byte(8'h05);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midreset busy", 128'(busy), 128'd0);
    check("midreset err", 128'(err_cnt), 128'd0);
    check("midreset regs", 128'(regs_flat), 128'd0);
    send_byte(8'hAA);
    expect_response("after midreset", 8'h3F);
    check("midreset reg5", 128'(regs_flat[47:40]), 128'd0);
    check("midreset err after", 128'(err_cnt), 128'd1);

    // saturation: hold rx_done high in WAIT_TX for many cycles
    send_byte(8'h10);
    check("sat prep err", 128'(err_cnt), 128'd2);
    @(posedge clk); #1;
    bus.rx_data = 8'h00; bus.rx_done = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    check("err saturate", 128'(err_cnt), 128'd255);
    pulse_tx_done();
    check("sat idle", 128'(busy), 128'd0);
    send_byte(8'h99);
    check("err stays 255", 128'(err_cnt), 128'd255);
    expect_response("bad opcode sat", 8'h3F);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
